mem_port_arbiter: RTL and testbench

- Shares one single-port, word-organised SRAM (1-cycle read latency) between the instruction-fetch requester (IF) and the load/store requester (LS) of the RV32I core.
- Serialises requests with valid/ready handshakes and returns one response per accepted request.
- Arbitration favours LS, with a starvation bound that guarantees IF progress.
- Sits between the core's fetch/memory stages and the shared memory macro.

---
 rtl/mem_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, word-organised SRAM (1-cycle read latency) between
// the instruction-fetch requester (IF) and the load/store requester (LS).
// Requests are serialised through a three-state FSM (IDLE -> ACCESS -> RESP),
// so at most one transaction is in flight and each accepted request gets
// exactly one single-cycle response.
//
// Arbitration prefers LS. While IF waits, a counter tracks consecutive LS
// grants; once it reaches STARVE_LIMIT the next contended grant goes to IF.
//
// Ports:
//   clk_i, rstn_i                 clock, synchronous active-low reset
//   if_req_valid_i/ready_o        IF request handshake
//   if_addr_i                     IF byte address
//   if_rsp_valid_o/data_o         IF read response (single-cycle pulse)
//   ls_req_valid_i/ready_o        LS request handshake
//   ls_addr_i, ls_we_i, ls_be_i,
//   ls_wdata_i                    LS request payload
//   ls_rsp_valid_o/data_o         LS response (read data, or 0 for writes)
//   mem_en_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o       SRAM command (word address)
//   mem_rdata_i                   SRAM read data, valid the cycle after a read
//   busy_o                        FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_rsp_valid_o,
    output logic [XLEN-1:0]   if_rsp_data_o,

    input  logic              ls_req_valid_i,
    output logic              ls_req_ready_o,
    input  logic [XLEN-1:0]   ls_addr_i,
    input  logic              ls_we_i,
    input  logic [3:0]        ls_be_i,
    input  logic [XLEN-1:0]   ls_wdata_i,
    output logic              ls_rsp_valid_o,
    output logic [XLEN-1:0]   ls_rsp_data_o,

    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam int unsigned       CntW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0]   StarveMax = CntW'(STARVE_LIMIT);

    state_e              r_state;
    logic [CntW-1:0]     r_starve_cnt;
    logic                r_owner_ls;     // 1 = LS owns the transaction in flight
    logic                r_rsp_we;       // transaction in RESP was a write

    // Latched request, presented to the SRAM during ACCESS and zero otherwise
    logic                r_mem_en;
    logic                r_mem_we;
    logic [3:0]          r_mem_be;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;

    logic                r_if_rsp_valid;
    logic                r_ls_rsp_valid;

    logic                w_idle;
    logic                w_starved;
    logic                w_if_grant;
    logic                w_ls_grant;
    logic                w_unused_addr_bits;

    // -------------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE; grants double as ready)
    // -------------------------------------------------------------------------
    always_comb begin
        w_idle     = (r_state == StIdle);
        w_starved  = (r_starve_cnt == StarveMax);
        w_if_grant = w_idle && if_req_valid_i && (!ls_req_valid_i || w_starved);
        w_ls_grant = w_idle && ls_req_valid_i && !(if_req_valid_i && w_starved);
    end

    // Byte-offset bits and bits above the word address are deliberately dropped
    assign w_unused_addr_bits = ^{if_addr_i[1:0], if_addr_i[XLEN-1:ADDR_W+2],
                                  ls_addr_i[1:0], ls_addr_i[XLEN-1:ADDR_W+2]};

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state        <= StIdle;
            r_starve_cnt   <= '0;
            r_owner_ls     <= 1'b0;
            r_rsp_we       <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_be       <= '0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_if_rsp_valid <= 1'b0;
            r_ls_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_if_grant || w_ls_grant) begin
                        r_owner_ls <= w_ls_grant;
                        r_mem_en   <= 1'b1;
                        if (w_ls_grant) begin
                            r_mem_addr  <= ls_addr_i[ADDR_W+1:2];
                            r_mem_we    <= ls_we_i;
                            r_mem_be    <= ls_be_i;
                            r_mem_wdata <= ls_wdata_i;
                        end else begin
                            r_mem_addr  <= if_addr_i[ADDR_W+1:2];
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= 4'hF;
                            r_mem_wdata <= '0;
                        end
                        r_state <= StAccess;
                    end

                    // Count only LS wins that actually made IF wait
                    if (w_if_grant) begin
                        r_starve_cnt <= '0;
                    end else if (w_ls_grant && if_req_valid_i && !w_starved) begin
                        r_starve_cnt <= r_starve_cnt + 1'b1;
                    end
                end

                StAccess: begin
                    r_rsp_we       <= r_mem_we;
                    r_if_rsp_valid <= !r_owner_ls;
                    r_ls_rsp_valid <= r_owner_ls;
                    r_mem_en       <= 1'b0;
                    r_mem_we       <= 1'b0;
                    r_mem_be       <= '0;
                    r_mem_addr     <= '0;
                    r_mem_wdata    <= '0;
                    r_state        <= StResp;
                end

                StResp: begin
                    r_if_rsp_valid <= 1'b0;
                    r_ls_rsp_valid <= 1'b0;
                    r_rsp_we       <= 1'b0;
                    r_owner_ls     <= 1'b0;
                    r_state        <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Gating with rstn_i keeps every output quiet while reset is held,
    // which also suppresses the SRAM write of a transaction cut off in ACCESS.
    // -------------------------------------------------------------------------
    assign if_req_ready_o = rstn_i && w_if_grant;
    assign ls_req_ready_o = rstn_i && w_ls_grant;

    assign if_rsp_valid_o = rstn_i && r_if_rsp_valid;
    assign ls_rsp_valid_o = rstn_i && r_ls_rsp_valid;

    // Read data comes straight from the SRAM, which presents it in RESP
    assign if_rsp_data_o  = (rstn_i && r_if_rsp_valid) ? mem_rdata_i : '0;
    assign ls_rsp_data_o  = (rstn_i && r_ls_rsp_valid && !r_rsp_we) ? mem_rdata_i : '0;

    assign mem_en_o       = rstn_i && r_mem_en;
    assign mem_we_o       = rstn_i && r_mem_we;
    assign mem_be_o       = rstn_i ? r_mem_be    : '0;
    assign mem_addr_o     = rstn_i ? r_mem_addr  : '0;
    assign mem_wdata_o    = rstn_i ? r_mem_wdata : '0;

    assign busy_o         = rstn_i && (r_state != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk_i;
    logic        rstn_i;
    logic        if_req_valid_i;
    logic        if_req_ready_o;
    logic [31:0] if_addr_i;
    logic        if_rsp_valid_o;
    logic [31:0] if_rsp_data_o;
    logic        ls_req_valid_i;
    logic        ls_req_ready_o;
    logic [31:0] ls_addr_i;
    logic        ls_we_i;
    logic [3:0]  ls_be_i;
    logic [31:0] ls_wdata_i;
    logic        ls_rsp_valid_o;
    logic [31:0] ls_rsp_data_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [10:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int n_total = 0;
    int n_bad   = 0;

    mem_port_arbiter #(
        .XLEN         (32),
        .ADDR_W       (11),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .if_req_valid_i (if_req_valid_i),
        .if_req_ready_o (if_req_ready_o),
        .if_addr_i      (if_addr_i),
        .if_rsp_valid_o (if_rsp_valid_o),
        .if_rsp_data_o  (if_rsp_data_o),
        .ls_req_valid_i (ls_req_valid_i),
        .ls_req_ready_o (ls_req_ready_o),
        .ls_addr_i      (ls_addr_i),
        .ls_we_i        (ls_we_i),
        .ls_be_i        (ls_be_i),
        .ls_wdata_i     (ls_wdata_i),
        .ls_rsp_valid_o (ls_rsp_valid_o),
        .ls_rsp_data_o  (ls_rsp_data_o),
        .mem_en_o       (mem_en_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i),
        .busy_o         (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // SRAM model: byte-enabled write, 1-cycle read latency
    logic [31:0] mem [0:2047];
    logic        tb_init;

    always @(posedge clk_i) begin
        if (tb_init) begin
            mem[11'h010] <= 32'hDEADBEEF;
            mem[11'h004] <= 32'hCAFEF00D;
            mem[11'h011] <= 32'h11223344;
            mem[11'h020] <= 32'h00000000;
        end else if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end else begin
                mem_rdata_i <= mem[mem_addr_o];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full transaction; entered and left #1 after a rising edge
    task automatic txn(input string tag, input bit is_ls, input logic we,
                       input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [10:0] exp_word,
                       input logic [31:0] exp_rd);
        if (is_ls) begin
            ls_req_valid_i = 1'b1; ls_addr_i = addr; ls_we_i = we;
            ls_be_i = be; ls_wdata_i = wd;
        end else begin
            if_req_valid_i = 1'b1; if_addr_i = addr;
        end
        @(negedge clk_i);
        check({tag, "_rdy"},  {31'b0, is_ls ? ls_req_ready_o : if_req_ready_o}, 32'd1);
        check({tag, "_ordy"}, {31'b0, is_ls ? if_req_ready_o : ls_req_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_en"},    {30'b0, mem_en_o, busy_o}, 32'd3);
        check({tag, "_addr"},  {21'b0, mem_addr_o}, {21'b0, exp_word});
        check({tag, "_we"},    {31'b0, mem_we_o}, {31'b0, is_ls & we});
        check({tag, "_be"},    {28'b0, mem_be_o}, {28'b0, is_ls ? be : 4'hF});
        check({tag, "_wdata"}, mem_wdata_o, is_ls ? wd : 32'h0);
        @(negedge clk_i);
        check({tag, "_rspv"},  {30'b0, if_rsp_valid_o, ls_rsp_valid_o},
              is_ls ? 32'd1 : 32'd2);
        check({tag, "_rspd"},  is_ls ? ls_rsp_data_o : if_rsp_data_o,
              (is_ls && we) ? 32'h0 : exp_rd);
        @(negedge clk_i);
        check({tag, "_after"}, {29'b0, if_rsp_valid_o, ls_rsp_valid_o, busy_o}, 32'd0);
        @(posedge clk_i); #1;
    endtask

    int exp_ls [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int grants;
        int last_cyc;

        tb_init        = 1'b1;
        rstn_i         = 1'b0;
        if_req_valid_i = 1'b1;
        if_addr_i      = 32'h8000_0040;
        ls_req_valid_i = 1'b1;
        ls_addr_i      = 32'h44;
        ls_we_i        = 1'b1;
        ls_be_i        = 4'hF;
        ls_wdata_i     = 32'hFFFF_FFFF;

        // Reset with both valids asserted: every output must stay 0
        @(posedge clk_i); #1;
        tb_init = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("rst_ctl", {25'b0, if_req_ready_o, ls_req_ready_o, mem_en_o, mem_we_o,
                              busy_o, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
            check("rst_mem", {17'b0, mem_be_o, mem_addr_o} | mem_wdata_o, 32'd0);
            check("rst_rsp", if_rsp_data_o | ls_rsp_data_o, 32'd0);
        end
        @(posedge clk_i); #1;
        ls_req_valid_i = 1'b0;
        if_req_valid_i = 1'b0;
        rstn_i         = 1'b1;

        txn("if_rd", 1'b0, 1'b0, 32'h8000_0040, 4'hF, 32'h0, 11'h010, 32'hDEADBEEF);
        txn("ls_wr", 1'b1, 1'b1, 32'h44, 4'b0010, 32'h0000_AB00, 11'h011, 32'h0);
        txn("ls_rd", 1'b1, 1'b0, 32'h44, 4'hF, 32'h0, 11'h011, 32'h1122AB44);
        txn("wrap",  1'b0, 1'b0, 32'h0000_2010, 4'hF, 32'h0, 11'h004, 32'hCAFEF00D);

        // Contention from a fresh starve counter
        rstn_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); #1;
        rstn_i         = 1'b1;
        if_req_valid_i = 1'b1; if_addr_i = 32'h100;
        ls_req_valid_i = 1'b1; ls_addr_i = 32'h200; ls_we_i = 1'b0; ls_be_i = 4'hF;
        grants   = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            @(negedge clk_i);
            check("dual_rdy", {31'b0, if_req_ready_o & ls_req_ready_o}, 32'd0);
            if (if_req_ready_o || ls_req_ready_o) begin
                check($sformatf("grant%0d", grants), {31'b0, ls_req_ready_o},
                      exp_ls[grants]);
                if (grants > 0) check("spacing", cyc - last_cyc, 32'd3);
                last_cyc = cyc;
                grants++;
            end
        end
        check("grant_cnt", grants, 32'd10);
        @(posedge clk_i); #1;
        if_req_valid_i = 1'b0;
        ls_req_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;

        // Reset asserted during the ACCESS cycle of an LS write
        ls_req_valid_i = 1'b1; ls_addr_i = 32'h80; ls_we_i = 1'b1;
        ls_be_i = 4'hF; ls_wdata_i = 32'h1234_5678;
        @(negedge clk_i);
        check("midrst_rdy", {31'b0, ls_req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        ls_req_valid_i = 1'b0;
        rstn_i         = 1'b0;
        @(negedge clk_i);
        check("midrst_en", {30'b0, mem_en_o, mem_we_o}, 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_rsp", {30'b0, ls_rsp_valid_o, busy_o}, 32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("midrst_idle", {29'b0, ls_rsp_valid_o, if_rsp_valid_o, busy_o}, 32'd0);
        @(posedge clk_i); #1;
        txn("midrst_rd", 1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 11'h020, 32'h0);

        // Idle: nothing moves without a valid
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("idle", {28'b0, mem_en_o, busy_o, if_rsp_valid_o, ls_rsp_valid_o}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
